nitc_mc_ctrl: RTL

NITC_MC_CTRL -- requirements
Module: nitc_mc_ctrl

---
 rtl/nitc_pkg.sv | 59 +++++
 rtl/nitc_wait_timer.sv | 40 ++++
 rtl/nitc_mc_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nitc_pkg.sv
// Shared definitions for the multi-cycle controller: state encoding,
// opcodes, condition codes and datapath mux/ALU select encodings.
package nitc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_JAL    = 4'd9,
    S_TRAP   = 4'd10
  } state_e;

  // Opcodes taken from IR[15:12]
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_NAND = 4'b0010;
  localparam logic [3:0] OP_SW   = 4'b1001;
  localparam logic [3:0] OP_LW   = 4'b1010;
  localparam logic [3:0] OP_BEQ  = 4'b1011;
  localparam logic [3:0] OP_JAL  = 4'b1101;

  // Condition field IR[1:0]
  localparam logic [1:0] CZ_ALWAYS = 2'b00;
  localparam logic [1:0] CZ_ZERO   = 2'b01;
  localparam logic [1:0] CZ_CARRY  = 2'b10;
  localparam logic [1:0] CZ_BAD    = 2'b11;

  // ALU operation select
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;

  // PC source select
  localparam logic [1:0] PC_ALU = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JAL = 2'b10;

  // ALU B-operand select
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;

  // Register destination select
  localparam logic [1:0] RD_86  = 2'b00;
  localparam logic [1:0] RD_53  = 2'b01;
  localparam logic [1:0] RD_119 = 2'b10;

  // States in which the controller waits on mem_ready
  function automatic logic is_wait(input state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/nitc_wait_timer.sv
// Memory-wait timeout counter. Cleared on entry to a wait state, counts
// cycles while waiting; expire_o flags the cycle that would be the
// (2^TO_W-1)-th consecutive wait cycle.
module nitc_wait_timer #(
  parameter int TO_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [TO_W-1:0] LAST = {{(TO_W-1){1'b1}}, 1'b0};

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  // Next count: clear wins, otherwise count waiting cycles
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/nitc_mc_ctrl.sv
// Multi-cycle controller for the NITC 16-bit CPU: instruction decode,
// datapath control, condition flags and memory-wait timeout.
// Optional macro NITC_JAL_EN enables the JAL state; without it opcode
// 1101 decodes as illegal.
module nitc_mc_ctrl
  import nitc_pkg::*;
#(
  parameter int TO_W = 4,
  parameter int OP_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] op,
  input  logic [1:0]      cz,
  input  logic            zero,
  input  logic            carry_in,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_we,
  output logic            iord,
  output logic            ir_write,
  output logic            pc_write,
  output logic [1:0]      pc_source,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic            reg_write,
  output logic [1:0]      reg_dst,
  output logic            mem_to_reg,
  output logic            carry_flag,
  output logic            zero_flag,
  output logic [3:0]      state_o,
  output logic            illegal,
  output logic            timeout,
  output logic            instr_done
);

  state_e     state_q, state_d;
  logic       carry_flag_q, zero_flag_q;
  logic       pend_c_q, pend_z_q;
  logic       timeout_q;
  logic       flag_commit;
  logic       cond_true;
  logic       tmr_clear, tmr_en, tmr_expire;
  logic [3:0] opc;

  assign opc = 4'(op);

  // Wait timer runs while sitting in a wait state without mem_ready
  assign tmr_en    = is_wait(state_q) && !mem_ready;
  assign tmr_clear = is_wait(state_d) && (state_d != state_q);

  nitc_wait_timer #(.TO_W(TO_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (tmr_clear),
    .en_i     (tmr_en),
    .expire_o (tmr_expire)
  );

  // Write-back condition from the cz field and the committed flags
  always_comb begin
    cond_true = 1'b0;
    case (cz)
      CZ_ALWAYS: cond_true = 1'b1;
      CZ_CARRY:  cond_true = carry_flag_q;
      CZ_ZERO:   cond_true = zero_flag_q;
      default:   cond_true = 1'b0;
    endcase
  end

  // Next state and per-state control outputs; anything unlisted stays 0
  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_source   = PC_ALU;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_REG;
    alu_op      = ALU_ADD;
    reg_write   = 1'b0;
    reg_dst     = RD_86;
    mem_to_reg  = 1'b0;
    illegal     = 1'b0;
    instr_done  = 1'b0;
    flag_commit = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_ONE;
        alu_op    = ALU_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (tmr_expire) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_SHIMM;
        case (opc)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_ADD, OP_NAND: begin
            if (cz == CZ_BAD) begin
              illegal = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_EXEC;
            end
          end
          OP_BEQ: state_d = S_BEQ;
`ifdef NITC_JAL_EN
          OP_JAL: state_d = S_JAL;
`endif
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opc == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (tmr_expire) begin
          state_d = S_TRAP;
        end
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (tmr_expire) begin
          state_d = S_TRAP;
        end
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        reg_dst    = RD_86;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNC;
        state_d   = S_RWB;
      end
      S_RWB: begin
        instr_done = 1'b1;
        if (cond_true) begin
          reg_write   = 1'b1;
          reg_dst     = RD_53;
          flag_commit = 1'b1;
        end
        state_d = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_source  = PC_BR;
        pc_write   = zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
`ifdef NITC_JAL_EN
      S_JAL: begin
        pc_source  = PC_JAL;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        reg_dst    = RD_119;
        mem_to_reg = 1'b0;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
`endif
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    // Reset must drop memory requests and pulses immediately, not at the next edge
    if (!reset) begin
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      iord        = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_source   = PC_ALU;
      alu_src_a   = 1'b0;
      alu_src_b   = SRCB_REG;
      alu_op      = ALU_ADD;
      reg_write   = 1'b0;
      reg_dst     = RD_86;
      mem_to_reg  = 1'b0;
      illegal     = 1'b0;
      instr_done  = 1'b0;
      flag_commit = 1'b0;
    end
  end

  // State register, flags, pending ALU flags and sticky timeout
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_FETCH;
      carry_flag_q <= 1'b0;
      zero_flag_q  <= 1'b0;
      pend_c_q     <= 1'b0;
      pend_z_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_EXEC) begin
        pend_c_q <= carry_in;
        pend_z_q <= zero;
      end
      if (flag_commit) begin
        zero_flag_q <= pend_z_q;
        if (opc == OP_ADD) begin
          carry_flag_q <= pend_c_q;
        end
      end
      if (tmr_expire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign state_o    = state_q;
  assign carry_flag = carry_flag_q;
  assign zero_flag  = zero_flag_q;
  assign timeout    = timeout_q;

endmodule
